keypad_entry_display: RTL and testbench



---
 rtl/keypad_entry_display_if.sv | 36 +++
 rtl/keypad_entry_display.sv | 259 +++++++++++++++++++++++++
 tb/tb_keypad_entry_display.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_display_if.sv
`timescale 1ns/1ps
// keypad_entry_display_if
// Pin-level bundle between the keypad/display pins and keypad_entry_display.
//   filas_raw  : raw keypad rows (pulled up, low = pressed on driven column)
//   columnas   : column drive, exactly one bit low
//   d          : 7-segment pattern {g..a}, active-high
//   a          : digit enables, one-hot active-low
//   key_valid  : one-cycle pulse on an accepted key
//   key_code   : last accepted key, row*COLS+col
//   digits     : digit buffer, digit 0 (newest) in bits [3:0]
// Modports:
//   master : the keypad/display block, which drives columns, display and key outputs
//   slave  : the pin side, which drives the raw rows
interface keypad_entry_display_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NUM_DIGITS = 3
);
    logic [ROWS-1:0]         filas_raw;
    logic [COLS-1:0]         columnas;
    logic [6:0]              d;
    logic [NUM_DIGITS-1:0]   a;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic [4*NUM_DIGITS-1:0] digits;

    modport master (
        input  filas_raw,
        output columnas, d, a, key_valid, key_code, digits
    );

    modport slave (
        output filas_raw,
        input  columnas, d, a, key_valid, key_code, digits
    );
endinterface

// File: rtl/keypad_entry_display.sv
`timescale 1ns/1ps
// keypad_entry_display
// Scans a ROWS x COLS matrix keypad, synchronises and debounces the rows,
// encodes one key per press, shifts accepted keys into a NUM_DIGITS-deep
// digit buffer and time-multiplexes that buffer onto a 7-segment bus.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : keypad_entry_display_if.master (rows in; columns, segments,
//          digit enables, key_valid/key_code and digit buffer out)
// Parameter limits: ROWS*COLS <= 16, NUM_DIGITS >= 1, SCAN_DIV >= 3.
// Optional feature macro: BLANK_UNENTERED_EN
//   When defined, digits that have not yet received a key show blank
//   segments; the digits bus itself is unaffected.
module keypad_entry_display #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int NUM_DIGITS      = 3,
    parameter int SCAN_DIV        = 2700,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REFRESH_DIV     = 27000
) (
    input  logic                         clk,
    input  logic                         rst,
    keypad_entry_display_if.master       bus
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int EW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [ROWS-1:0] fs_meta, fs;
    state_t          state, state_next;
    logic [SW-1:0]   scan_cnt, scan_next;
    logic [CW-1:0]   col_idx, col_next, col_inc;
    logic [DW-1:0]   deb_cnt, deb_next;
    logic [ROWS-1:0] pat, pat_next;
    logic [3:0]      pend_code, code_next, code_calc;
    logic            accept;
    int              row_sel;

    logic [3:0]      digit_buf [NUM_DIGITS];
    logic            key_valid_q;
    logic [3:0]      key_code_q;

    logic [RW-1:0]   ref_cnt;
    logic [IW-1:0]   dig_idx;
    logic [NUM_DIGITS-1:0] a_q, a_calc;
    logic [6:0]      d_q, d_calc;
    logic            blank;
    logic [COLS-1:0] col_drive;
    logic [4*NUM_DIGITS-1:0] digits_flat;

    // Two-flop synchroniser; idle keypad reads all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_meta <= '1;
            fs      <= '1;
        end else begin
            fs_meta <= bus.filas_raw;
            fs      <= fs_meta;
        end
    end

    // Key code of the lowest-index low row on the currently driven column.
    always_comb begin
        row_sel = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!fs[r]) row_sel = r;
        end
        code_calc = 4'(row_sel * COLS) + 4'(col_idx);
        col_inc   = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;
    end

    // Keypad FSM next-state: scan columns, debounce the latched row pattern,
    // wait for release, then debounce the release before scanning again.
    always_comb begin
        state_next = state;
        scan_next  = scan_cnt;
        col_next   = col_idx;
        deb_next   = deb_cnt;
        pat_next   = pat;
        code_next  = pend_code;
        accept     = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                    scan_next = '0;
                    if (fs != '1) begin
                        pat_next   = fs;
                        code_next  = code_calc;
                        deb_next   = '0;
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_inc;
                    end
                end else begin
                    scan_next = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (fs != pat) begin
                    deb_next   = '0;
                    scan_next  = '0;
                    col_next   = col_inc;
                    state_next = SCAN;
                end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_next   = '0;
                    accept     = 1'b1;
                    state_next = HELD;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (fs == '1) begin
                    deb_next   = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (fs != '1) begin
                    deb_next   = '0;
                    state_next = HELD;
                end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_next   = '0;
                    scan_next  = '0;
                    col_next   = '0;
                    state_next = SCAN;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Keypad FSM registers, key outputs and the digit shift buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            scan_cnt    <= '0;
            col_idx     <= '0;
            deb_cnt     <= '0;
            pat         <= '1;
            pend_code   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= '0;
        end else begin
            state       <= state_next;
            scan_cnt    <= scan_next;
            col_idx     <= col_next;
            deb_cnt     <= deb_next;
            pat         <= pat_next;
            pend_code   <= code_next;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= pend_code;
                for (int i = NUM_DIGITS - 1; i > 0; i--) digit_buf[i] <= digit_buf[i-1];
                digit_buf[0] <= pend_code;
            end
        end
    end

`ifdef BLANK_UNENTERED_EN
    logic [EW-1:0] entry_cnt;

    // Number of digits that have received a key, saturating at NUM_DIGITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_cnt <= '0;
        end else if (accept && entry_cnt != EW'(NUM_DIGITS)) begin
            entry_cnt <= entry_cnt + 1'b1;
        end
    end

    assign blank = (EW'(dig_idx) >= entry_cnt);
`else
    assign blank = 1'b0;
`endif

    // Segment and enable values for the currently indexed digit.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) a_calc[i] = (dig_idx != IW'(i));
        d_calc = blank ? 7'b0000000 : hex_to_seg(digit_buf[dig_idx]);
    end

    // Display refresh: a and d are both registered from the same index so
    // they switch on the same edge and no digit shows its neighbour's segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            dig_idx <= '0;
            a_q     <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
`ifdef BLANK_UNENTERED_EN
            d_q     <= 7'b0000000;
`else
            d_q     <= 7'h3F;
`endif
        end else begin
            a_q <= a_calc;
            d_q <= d_calc;
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                dig_idx <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

    // Column drive and flattened digit buffer.
    always_comb begin
        for (int c = 0; c < COLS; c++) col_drive[c] = (col_idx != CW'(c));
        for (int i = 0; i < NUM_DIGITS; i++) digits_flat[i*4 +: 4] = digit_buf[i];
    end

    assign bus.columnas  = col_drive;
    assign bus.a         = a_q;
    assign bus.d         = d_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.digits    = digits_flat;

endmodule

// File: tb/tb_keypad_entry_display.sv
`timescale 1ns/1ps
// tb_keypad_entry_display
// Self-checking bench: a behavioural 4x4 keypad drives the rows from the
// column drive; every intended key press pushes its expected code and
// resulting digit buffer to a queue, popped whenever key_valid pulses.
module tb_keypad_entry_display;

    localparam int ROWS = 4, COLS = 4, NUM_DIGITS = 3;

    typedef struct {
        logic [3:0]  code;
        logic [11:0] digits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0] rows_model;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int pushes = 0;
    exp_t exp_q [$];
    logic [11:0] exp_digits = '0;
    int exp_count = 0;

    keypad_entry_display_if #(.ROWS(ROWS), .COLS(COLS), .NUM_DIGITS(NUM_DIGITS)) bus ();

    keypad_entry_display #(
        .ROWS(ROWS), .COLS(COLS), .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REFRESH_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        rows_model = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!bus.columnas[c] && pressed[r*COLS + c]) rows_model[r] = 1'b0;
    end
    assign bus.filas_raw = rows_model;

    function automatic logic [6:0] segModel(input logic [3:0] v);
        logic [6:0] table_v [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return table_v[v];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic pushExpected(input logic [3:0] code);
        exp_t e;
        exp_digits = {exp_digits[7:0], code};
        if (exp_count < NUM_DIGITS) exp_count++;
        e.code = code;
        e.digits = exp_digits;
        exp_q.push_back(e);
        pushes++;
    endtask

    task automatic clearModel();
        exp_digits = '0;
        exp_count = 0;
        exp_q.delete();
    endtask

    // Press a key mask, hold it, and require the expected pulse to have been seen.
    task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] code, input int hold);
        pushExpected(code);
        pressed = mask;
        repeat (hold) @(negedge clk);
        checkOutput("key_seen_in_time", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic releaseKeys(input int cycles);
        pressed = '0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        clearModel();
        rst = 1'b0;
    endtask

    // Watch the multiplexed display and compare each lit digit with the model.
    task automatic checkDisplay();
        logic [2:0] seen;
        int idx;
        logic [6:0] exp_seg;
        seen = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            case (bus.a)
                3'b110:  idx = 0;
                3'b101:  idx = 1;
                3'b011:  idx = 2;
                default: idx = -1;
            endcase
            checkOutput("a_onehot_low", (idx >= 0) ? 1 : 0, 1);
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                exp_seg = segModel(exp_digits[idx*4 +: 4]);
`ifdef BLANK_UNENTERED_EN
                if (idx >= exp_count) exp_seg = 7'b0000000;
`endif
                checkOutput("segments", bus.d, exp_seg);
            end
        end
        checkOutput("all_digits_lit", seen, 3'b111);
    endtask

    // Scoreboard side: every key_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.key_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("key_code", bus.key_code, e.code);
                checkOutput("digits_after_key", bus.digits, e.digits);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] col_seq [5];
        logic [6:0] rst_seg;
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
`ifdef BLANK_UNENTERED_EN
        rst_seg = 7'b0000000;
`else
        rst_seg = 7'h3F;
`endif
        $display("[TB] reset and column scan");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_columnas", bus.columnas, 4'b1110);
        checkOutput("rst_a", bus.a, 3'b110);
        checkOutput("rst_digits", bus.digits, 12'h000);
        checkOutput("rst_key_valid", bus.key_valid, 1'b0);
        checkOutput("rst_key_code", bus.key_code, 4'h0);
        checkOutput("rst_d", bus.d, rst_seg);
        for (int k = 0; k < 5; k++) begin
            repeat ((k == 0) ? 2 : 4) @(negedge clk);
            checkOutput("scan_sequence", bus.columnas, col_seq[k]);
        end

        $display("[TB] clean press key 9");
        applyStimulus(16'h0200, 4'd9, 40);
        pressed = '0;
        repeat (9) @(negedge clk);
        checkOutput("release_still_frozen", bus.columnas, 4'b1101);
        repeat (3) @(negedge clk);
        checkOutput("release_resume_col0", bus.columnas, 4'b1110);
        repeat (10) @(negedge clk);

        $display("[TB] bouncing press key 3");
        pushExpected(4'd3);
        pressed = 16'h0008;
        repeat (5) @(negedge clk);
        pressed = '0;
        @(negedge clk);
        pressed = 16'h0008;
        repeat (40) @(negedge clk);
        checkOutput("bounce_key_seen", exp_q.size(), 0);
        exp_q.delete();
        releaseKeys(20);

        $display("[TB] buffer shift 1 2 3 4");
        doReset();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(16'h0001 << k, 4'(k), 40);
            releaseKeys(20);
        end
        checkOutput("buffer_after_four", bus.digits, 12'h234);
        checkDisplay();

        $display("[TB] two rows on column 0, then column 2 while held");
        applyStimulus(16'h1010, 4'd4, 40);
        pressed = pressed | 16'h0004;
        repeat (30) @(negedge clk);
        releaseKeys(20);
        checkOutput("buffer_after_two_rows", bus.digits, 12'h344);

        $display("[TB] reset during debounce");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clearModel();
        pressed = 16'h0001;
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_key_valid", bus.key_valid, 1'b0);
        checkOutput("midrst_columnas", bus.columnas, 4'b1110);
        checkOutput("midrst_digits", bus.digits, 12'h000);
        checkOutput("midrst_key_code", bus.key_code, 4'h0);
        pressed = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single key after reset and display");
        applyStimulus(16'h0020, 4'd5, 40);
        releaseKeys(20);
        checkDisplay();

        checkOutput("pulse_count", pulses, pushes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
